// File: rtl/clock_domain_pkg.sv
// Shared definitions for the clock-domain export path: FSM state codes, the
// requester-index width helper and the default ack-wait limit.
package clock_domain_pkg;

  localparam int unsigned DefaultTimeout = 1024;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StLoad = 2'd1;
  localparam state_t StWait = 2'd2;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit signal entering this clock domain.
// Both flops clear on synchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/clock_domain_export_arbiter.sv
// Round-robin front end sharing one toggle-handshake crossing among NREQ requesters.
// Optional ack-wait timeout flag is built when CLOCK_DOMAIN_ARB_TIMEOUT_EN is defined.
module clock_domain_export_arbiter
  import clock_domain_pkg::*;
#(
  parameter int unsigned SIZE    = 8,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = DefaultTimeout,
  localparam int unsigned IDW    = id_width(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*SIZE-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 busy,
  output logic [IDW+SIZE-1:0]  handshake_data,
  output logic                 handshake_req,
  input  logic                 handshake_ack,
  output logic                 err_timeout
);

  if (NREQ < 2 || NREQ > 16 || TIMEOUT == 0) begin : g_param_check
    $error("clock_domain_export_arbiter: NREQ must be 2..16 and TIMEOUT nonzero");
  end

  logic ack_s;

  sync_2ff u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (handshake_ack),
    .q     (ack_s)
  );

  state_t              state_q, state_d;
  logic [IDW-1:0]      prio_q, prio_d;
  logic [NREQ-1:0]     ready_q, ready_d;
  logic [IDW+SIZE-1:0] data_q, data_d;
  logic                hs_req_q, hs_req_d;
  logic [1:0]          settle_q;

  logic [SIZE-1:0] words [NREQ];
  logic            found;
  logic [IDW-1:0]  win;
  logic [IDW:0]    idx;

  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign words[g] = req_data[g*SIZE +: SIZE];
  end

  // First valid requester at or above prio, wrapping past NREQ-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = {1'b0, prio_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    ready_d  = '0;
    data_d   = data_q;
    hs_req_d = hs_req_q;
    case (state_q)
      StIdle: begin
        // settle_q holds off grants until the synchronizer has refilled after
        // reset, so a peer still showing ack=1 cannot be mistaken for ack=0.
        if (settle_q[1] && ack_s == hs_req_q && found) begin
          ready_d[win] = 1'b1;
          data_d       = {win, words[win]};
          prio_d       = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
          state_d      = StLoad;
        end
      end
      StLoad: begin
        hs_req_d = ~hs_req_q;
        state_d  = StWait;
      end
      StWait: begin
        if (ack_s == hs_req_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      prio_q   <= '0;
      ready_q  <= '0;
      data_q   <= '0;
      hs_req_q <= 1'b0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      ready_q  <= ready_d;
      data_q   <= data_d;
      hs_req_q <= hs_req_d;
      settle_q <= {settle_q[0], 1'b1};
    end
  end

  assign req_ready      = ready_q;
  assign busy           = (state_q != StIdle);
  assign handshake_data = data_q;
  assign handshake_req  = hs_req_q;

`ifdef CLOCK_DOMAIN_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // Counter saturates at TIMEOUT; the flag is sticky and never aborts the wait.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == StLoad) begin
      cnt_d = '0;
    end else if (state_q == StWait && cnt_q != CntW'(TIMEOUT)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CntW'(TIMEOUT)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_clock_domain_export_arbiter.sv
// Self-checking bench for clock_domain_export_arbiter with a delayed-echo ack peer.
// Honours CLOCK_DOMAIN_ARB_TIMEOUT_EN for the timeout expectations.
module tb_clock_domain_export_arbiter;

  localparam int NREQ = 4;
  localparam int SIZE = 8;
  localparam int IDW  = 2;
  localparam int TMO  = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*SIZE-1:0] req_data = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 busy;
  logic [IDW+SIZE-1:0]  handshake_data;
  logic                 handshake_req;
  logic                 handshake_ack = 1'b0;
  logic                 err_timeout;

  always #5 clk = ~clk;

  clock_domain_export_arbiter #(
    .SIZE    (SIZE),
    .NREQ    (NREQ),
    .TIMEOUT (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .busy           (busy),
    .handshake_data (handshake_data),
    .handshake_req  (handshake_req),
    .handshake_ack  (handshake_ack),
    .err_timeout    (err_timeout)
  );

  // Destination peer: echoes handshake_req after ack_delay extra cycles, or is pinned.
  bit ack_hold = 1'b0;
  bit ack_hold_val = 1'b0;
  int ack_delay = 0;
  int ack_cnt = 0;

  always @(posedge clk) begin
    if (ack_hold) begin
      handshake_ack <= ack_hold_val;
      ack_cnt       <= 0;
    end else if (handshake_ack != handshake_req) begin
      if (ack_cnt >= ack_delay) begin
        handshake_ack <= handshake_req;
        ack_cnt       <= 0;
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end else begin
      ack_cnt <= 0;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int m_prio = 0;
  bit m_req = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_winner(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  function automatic logic [SIZE-1:0] word_of(input logic [NREQ*SIZE-1:0] d, input int i);
    logic [NREQ*SIZE-1:0] t;
    t = d >> (i * SIZE);
    return t[SIZE-1:0];
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic transfer(input logic [NREQ-1:0] vec, input bit keep);
    int                  w;
    int                  cyc;
    logic [IDW-1:0]      wid;
    logic [IDW+SIZE-1:0] exp_data;
    logic [NREQ-1:0]     oh;
    w        = exp_winner(vec, m_prio);
    wid      = IDW'(w);
    exp_data = {wid, word_of(req_data, w)};
    oh       = NREQ'(1) << w;
    req_valid = vec;
    @(negedge clk);
    check("grant_ready", 32'(req_ready), 32'(oh));
    check("grant_data", 32'(handshake_data), 32'(exp_data));
    check("busy_load", 32'(busy), 32'd1);
    check("req_pre_toggle", 32'(handshake_req), 32'(m_req));
    m_prio = (w + 1) % NREQ;
    if (!keep) req_valid[w] = 1'b0;
    req_data = $urandom;
    @(negedge clk);
    m_req = ~m_req;
    check("req_toggle", 32'(handshake_req), 32'(m_req));
    check("ready_pulse", 32'(req_ready), 32'd0);
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      check("data_stable", 32'(handshake_data), 32'(exp_data));
      req_data = $urandom;
      @(negedge clk);
      cyc++;
    end
    check("wait_exit", 32'(busy), 32'd0);
  endtask

  initial begin
    int  cyc;
    bit  exp_err;
    logic [NREQ-1:0] vec;
    logic [IDW+SIZE-1:0] exp_data;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req", 32'(handshake_req), 32'd0);
    check("rst_data", 32'(handshake_data), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Round robin with all four valid: order 0,1,2,3,0
    ack_delay = 3;
    req_data  = $urandom;
    for (int i = 0; i < 5; i++) transfer(4'b1111, 1'b1);
    req_valid = '0;

    // Single request carrying 8'hA5 on requester 2
    ack_delay = 1;
    req_data  = $urandom;
    req_data[2*SIZE +: SIZE] = 8'hA5;
    exp_data  = {2'd2, 8'hA5};
    req_valid = 4'b0100;
    @(negedge clk);
    check("single_ready", 32'(req_ready), 32'h4);
    check("single_data", 32'(handshake_data), 32'(exp_data));
    req_valid = '0;
    m_prio    = 3;
    @(negedge clk);
    m_req = ~m_req;
    check("single_toggle", 32'(handshake_req), 32'(m_req));
    cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("single_done", 32'(busy), 32'd0);

    // Randomized transfers
    for (int i = 0; i < 25; i++) begin
      ack_delay = int'($urandom_range(0, 5));
      vec       = NREQ'($urandom_range(1, 15));
      req_data  = $urandom;
      transfer(vec, 1'b0);
      req_valid = '0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset during WAIT while the peer holds ack=1
    ack_delay = 0;
    if (m_req) transfer(4'b0001, 1'b0);
    req_valid = '0;
    req_data  = $urandom;
    req_valid = 4'b0001;
    @(negedge clk);
    check("rmid_grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    check("rmid_toggle", 32'(handshake_req), 32'd1);
    ack_hold     = 1'b1;
    ack_hold_val = 1'b1;
    @(negedge clk);
    check("rmid_in_wait", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    m_prio = 0;
    m_req  = 1'b0;
    check("rmid_rst_req", 32'(handshake_req), 32'd0);
    check("rmid_rst_data", 32'(handshake_data), 32'd0);
    check("rmid_rst_ready", 32'(req_ready), 32'd0);
    check("rmid_rst_busy", 32'(busy), 32'd0);
    check("rmid_rst_err", 32'(err_timeout), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rmid_blk_ready", 32'(req_ready), 32'd0);
      check("rmid_blk_req", 32'(handshake_req), 32'd0);
    end
    exp_data     = {2'd0, word_of(req_data, 0)};
    ack_hold_val = 1'b0;
    cyc = 0;
    while (req_ready === '0 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("rmid_regrant", 32'(req_ready), 32'h1);
    check("rmid_regrant_data", 32'(handshake_data), 32'(exp_data));
    ack_hold  = 1'b0;
    req_valid = '0;
    m_prio    = 1;
    @(negedge clk);
    m_req = 1'b1;
    check("rmid_retoggle", 32'(handshake_req), 32'(m_req));
    cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("rmid_done", 32'(busy), 32'd0);

    // Timeout: peer stops answering
    ack_hold     = 1'b1;
    ack_hold_val = m_req;
    req_valid    = 4'b0010;
    @(negedge clk);
    check("to_grant", 32'(req_ready), 32'h2);
    req_valid = '0;
    m_prio    = 2;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
`ifdef CLOCK_DOMAIN_ARB_TIMEOUT_EN
      exp_err = (i >= 17);
`else
      exp_err = 1'b0;
`endif
      check("to_err", 32'(err_timeout), 32'(exp_err));
      check("to_busy", 32'(busy), 32'd1);
    end
    m_req        = ~m_req;
    ack_hold_val = m_req;
    cyc = 0;
    while (busy === 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("to_release", 32'(busy), 32'd0);
`ifdef CLOCK_DOMAIN_ARB_TIMEOUT_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    check("to_err_sticky", 32'(err_timeout), 32'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clock_domain_export_arbiter.md
# clock_domain_export_arbiter

Source-domain controller that shares one toggle-handshake clock-domain crossing between `NREQ` local requesters. It picks a requester with a round-robin arbiter and captures its word plus the requester index into a stable `handshake_data` register. It then toggles `handshake_req` and waits for the synchronized `handshake_ack` to match before starting the next transfer. It sits directly in front of the destination-side importer that receives `handshake_data`, `handshake_req` and returns `handshake_ack`.

## Interface
- `SIZE`, 8, payload width per requester
- `NREQ`, 4, number of requesters (2..16)
- `IDW`, `$clog2(NREQ)`, requester-index width (derived, not overridden)
- `TIMEOUT`, 1024, ack-wait limit in cycles (used only with the macro)

- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `req_valid`  in  NREQ  requester i has a word pending; held until its `req_ready` pulse
- `req_data`  in  NREQ*SIZE  word of requester i at bits [i*SIZE +: SIZE]
- `req_ready`  out  NREQ  one-hot, one-cycle pulse: word of requester i captured
- `busy`  out  1  a transfer is in flight (state != IDLE)
- `handshake_data`  out  IDW+SIZE  {index, payload}; registered, stable while a transfer is in flight
- `handshake_req`  out  1  toggles once per transfer
- `handshake_ack`  in  1  asynchronous, from the destination domain
- `err_timeout`  out  1  sticky timeout flag; constant 0 without the macro

## Operation
- `handshake_ack` passes through a 2-FF synchronizer to give `ack_s`; no other logic samples raw `handshake_ack`.
- States:
  - IDLE: if `ack_s == handshake_req` and any `req_valid` is set, then grant winner w, load `handshake_data <= {w, req_data[w]}`, pulse `req_ready[w]`, go to LOAD. If `ack_s != handshake_req`, stay in IDLE and grant nothing; this waits out a peer that is out of step.
  - LOAD: `handshake_req <= ~handshake_req`; go to WAIT. Data is therefore stable at least one cycle before the toggle.
  - WAIT: when `ack_s == handshake_req`, go to IDLE. `handshake_data` is held unchanged throughout.
- Round-robin arbitration:
  - Pointer `prio` holds the highest-priority index; reset value 0.
  - The winner is the first set `req_valid` scanning from `prio` upward with wrap.
  - After a grant, `prio <= (w+1) mod NREQ`; NREQ not a power of two wraps correctly.
  - With no valid requester, `prio` is unchanged.
- `req_valid` deasserting without a grant is legal; the requester is simply not considered.
- The index field is placed in the MSBs of `handshake_data`; the payload is passed through unmodified.

## Timing
- Reset values: `handshake_req`=0, `handshake_data`=0, `req_ready`=0, `busy`=0, `err_timeout`=0, synchronizer flops=0, state=IDLE, `prio`=0.
- Grant latency: `req_ready` rises in the first IDLE cycle in which `req_valid` is high (registered output, high in the following cycle).
- `handshake_req` toggles exactly 1 cycle after the capture cycle.
- Minimum transfer: 1 (IDLE) + 1 (LOAD) + ack round trip + 2 synchronizer cycles in WAIT. Next grant at the earliest on the first IDLE cycle after WAIT exits.
- Simultaneous `req_valid` from several requesters: exactly one is granted per transfer; the others wait.
- Ack arrives in the same cycle the state enters WAIT: handled by the comparison, no special case.
- `rst_n` low mid-transfer: returns to IDLE with `handshake_req`=0. If the peer's ack is still 1, IDLE blocks until `ack_s` returns to 0; no spurious toggle is issued.

## Configuration
- `CLOCK_DOMAIN_ARB_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT+1)` clears on WAIT entry and increments each cycle in WAIT.
  - On reaching `TIMEOUT`, `err_timeout` sets and stays set until reset.
  - The FSM keeps waiting; a transfer is never aborted.
- Macro not defined: no counter is built and `err_timeout` is tied to 0.

## Structure
- Shared package `clock_domain_pkg`: state enum (IDLE, LOAD, WAIT), the ID-width helper function, and the default `TIMEOUT` constant.
- One sub-module `sync_2ff` (1-bit, reset to 0 on `rst_n`) for `handshake_ack`; the same module is reused for other single-bit crossings in the codebase.
- Arbiter logic stays inline in this module.

## Test plan
- Single request: NREQ=4, `req_valid`=4'b0100, `req_data[2]`=8'hA5. Expect `req_ready`=4'b0100 for 1 cycle, `handshake_data`={2'd2, 8'hA5}, `handshake_req` 0→1 one cycle later, `busy` low after the model acks.
- Round robin: all four valid continuously with an ack model of 3-cycle delay. Expect grant order 0,1,2,3,0; each requester gets 1 grant per 4 transfers.
- Data stability: randomly change `req_data` during WAIT. Expect `handshake_data` unchanged from capture until the next IDLE grant.
- Reset mid-transfer: assert `rst_n`=0 in WAIT while the ack model has driven ack=1. Expect all outputs at reset values, no `req_ready` or toggle until the model returns ack to 0, then normal transfer.
- Timeout, with macro and `TIMEOUT`=16: ack model never responds. Expect `err_timeout` high 16 cycles after WAIT entry, then held; a later ack returns to IDLE with `err_timeout` still 1.
- Timeout, without macro: same stimulus. Expect `err_timeout`=0 throughout and the FSM parked in WAIT.
